// File: rtl/ysyx_23060059_axi_pkg.sv
// Shared types and constants for the AXI read arbiter.
// Covers the two-master (IFU/LSU) to single-slave read path.
package ysyx_23060059_axi_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [ID_W-1:0]   DEF_ID_IFU = 4'd0;
  localparam logic [ID_W-1:0]   DEF_ID_LSU = 4'd1;
  localparam logic [RESP_W-1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    AR_IFU,
    AR_LSU,
    R_IFU,
    R_LSU
  } arb_state_e;
endpackage

// File: rtl/ysyx_23060059_rr_picker2.sv
// Two-way round-robin picker: bit 0 is IFU, bit 1 is LSU.
// On contention the side that was not granted last time wins.
module ysyx_23060059_rr_picker2 (
  input  logic [1:0] req,
  input  logic       last_lsu,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_lsu ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/ysyx_23060059_axi_rd_arbiter.sv
// Arbitrates IFU and LSU read requests onto one AXI read port, one
// transaction at a time, with a data-phase watchdog and sticky error flag.
module ysyx_23060059_axi_rd_arbiter
  import ysyx_23060059_axi_pkg::*;
#(
  parameter int              TIMEOUT = 1024,
  parameter logic [ID_W-1:0] ID_IFU  = DEF_ID_IFU,
  parameter logic [ID_W-1:0] ID_LSU  = DEF_ID_LSU
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  ifu_araddr,
  input  logic               ifu_arvalid,
  input  logic [LEN_W-1:0]   ifu_arlen,
  input  logic [SIZE_W-1:0]  ifu_arsize,
  input  logic [BURST_W-1:0] ifu_arburst,
  output logic               ifu_arready,
  output logic [DATA_W-1:0]  ifu_rdata,
  output logic [RESP_W-1:0]  ifu_rresp,
  output logic               ifu_rlast,
  output logic               ifu_rvalid,
  input  logic               ifu_rready,
  input  logic [ADDR_W-1:0]  lsu_araddr,
  input  logic               lsu_arvalid,
  input  logic [LEN_W-1:0]   lsu_arlen,
  input  logic [SIZE_W-1:0]  lsu_arsize,
  input  logic [BURST_W-1:0] lsu_arburst,
  output logic               lsu_arready,
  output logic [DATA_W-1:0]  lsu_rdata,
  output logic [RESP_W-1:0]  lsu_rresp,
  output logic               lsu_rlast,
  output logic               lsu_rvalid,
  input  logic               lsu_rready,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic               m_arvalid,
  output logic [ID_W-1:0]    m_arid,
  output logic [LEN_W-1:0]   m_arlen,
  output logic [SIZE_W-1:0]  m_arsize,
  output logic [BURST_W-1:0] m_arburst,
  input  logic               m_arready,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic [RESP_W-1:0]  m_rresp,
  input  logic               m_rlast,
  input  logic [ID_W-1:0]    m_rid,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic               timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e       state_reg, state_next;
  logic             last_lsu_reg, last_lsu_next;
  logic [CNT_W-1:0] wd_reg, wd_next;
  logic             err_reg, err_next;

  logic [1:0]        grant;
  logic [1:0]        ar_own, r_own, rready_v;
  logic [1:0]        arready_v, rvalid_v, rlast_v;
  logic [DATA_W-1:0] rdata_v [2];
  logic [RESP_W-1:0] rresp_v [2];
  logic              ar_hs, r_hs;
  logic [ID_W-1:0]   r_id_exp;

  ysyx_23060059_rr_picker2 u_picker (
    .req      ({lsu_arvalid, ifu_arvalid}),
    .last_lsu (last_lsu_reg),
    .grant    (grant)
  );

  // Ownership is forced off during reset so every output reads 0 immediately.
  assign ar_own   = reset ? 2'b00 : {state_reg == AR_LSU, state_reg == AR_IFU};
  assign r_own    = reset ? 2'b00 : {state_reg == R_LSU, state_reg == R_IFU};
  assign rready_v = {lsu_rready, ifu_rready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign arready_v[gi] = ar_own[gi] & m_arready;
    assign rvalid_v[gi]  = r_own[gi] & m_rvalid;
    assign rlast_v[gi]   = r_own[gi] & m_rlast;
    assign rdata_v[gi]   = r_own[gi] ? m_rdata : '0;
    assign rresp_v[gi]   = r_own[gi] ? m_rresp : '0;
  end

  assign ifu_arready = arready_v[0];
  assign ifu_rvalid  = rvalid_v[0];
  assign ifu_rlast   = rlast_v[0];
  assign ifu_rdata   = rdata_v[0];
  assign ifu_rresp   = rresp_v[0];
  assign lsu_arready = arready_v[1];
  assign lsu_rvalid  = rvalid_v[1];
  assign lsu_rlast   = rlast_v[1];
  assign lsu_rdata   = rdata_v[1];
  assign lsu_rresp   = rresp_v[1];
  assign m_rready    = |(r_own & rready_v);
  assign timeout_err = err_reg & ~reset;

  always_comb begin
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_arid    = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    if (ar_own[0]) begin
      m_araddr  = ifu_araddr;
      m_arvalid = ifu_arvalid;
      m_arid    = ID_IFU;
      m_arlen   = ifu_arlen;
      m_arsize  = ifu_arsize;
      m_arburst = ifu_arburst;
    end else if (ar_own[1]) begin
      m_araddr  = lsu_araddr;
      m_arvalid = lsu_arvalid;
      m_arid    = ID_LSU;
      m_arlen   = lsu_arlen;
      m_arsize  = lsu_arsize;
      m_arburst = lsu_arburst;
    end
  end

  assign ar_hs    = m_arvalid & m_arready;
  assign r_hs     = m_rvalid & m_rready;
  assign r_id_exp = (state_reg == R_LSU) ? ID_LSU : ID_IFU;

  always_comb begin
    state_next    = state_reg;
    last_lsu_next = last_lsu_reg;
    wd_next       = wd_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (grant[1])      state_next = AR_LSU;
        else if (grant[0]) state_next = AR_IFU;
      end
      AR_IFU, AR_LSU: begin
        if (ar_hs) begin
          state_next = (state_reg == AR_LSU) ? R_LSU : R_IFU;
          wd_next    = '0;
        end
      end
      R_IFU, R_LSU: begin
        if (r_hs && (m_rid != r_id_exp)) err_next = 1'b1;
        // A completing last beat wins over a watchdog expiring in the same cycle.
        if (r_hs && m_rlast) begin
          state_next    = IDLE;
          last_lsu_next = (state_reg == R_LSU);
        end else if (wd_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next = IDLE;
          err_next   = 1'b1;
          wd_next    = CNT_W'(TIMEOUT);
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_lsu_reg <= 1'b0;
      wd_reg       <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_lsu_reg <= last_lsu_next;
      wd_reg       <= wd_next;
      err_reg      <= err_next;
    end
  end
endmodule
